// File: rtl/clksel_ctrl.sv
// High-speed / low-speed CPU clock switch sequencer.
// Decides per bus cycle whether the CPU must run from the host (low-speed)
// clock, requests the switch, waits for confirmation and then grants the
// cycle. Slow mode is held for a hysteresis window after the last slow grant,
// and divider settings are applied only while the high-speed path is idle.
module clksel_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned HOLD_W         = 8,
  parameter int unsigned SWITCH_TIMEOUT = 255,
  parameter int unsigned TMO_W          = 8,
  parameter logic [3:0]  DIV_RST        = 4'h0
) (
  input  logic       hsclk_in,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_slow,
  output logic       req_ready,
  input  logic       cfg_we,
  input  logic [4:0] cfg_wdata,
  input  logic       hsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] hsclk_div_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       timeout_err
);

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LIMIT   = TMO_W'(SWITCH_TIMEOUT);

  typedef enum logic [1:0] {
    ST_SLOW    = 2'd0,
    ST_WAIT_HS = 2'd1,
    ST_FAST    = 2'd2,
    ST_WAIT_LS = 2'd3
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              hsclk_sel_q;
  logic              timeout_err_q;
  logic [3:0]        div_q;          // {hsclk_div_sel, cpuclk_div_sel} as applied
  logic              force_q, force_d;
  logic [3:0]        div_shadow_q, div_shadow_d;
  logic              cfg_pending_q;
  logic [HOLD_W-1:0] hold_q;
  logic [TMO_W-1:0]  tmo_q;

  logic             valid_eff;
  logic             want_slow;
  logic             pending_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_expired;

  // Shadow config as seen by this cycle's decision: a write lands before the request is judged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    force_d      = force_q;
    div_shadow_d = div_shadow_q;
    if (cfg_we) begin
      force_d      = cfg_wdata[4];
      div_shadow_d = cfg_wdata[3:0];
    end
  end

  // A request seen while its grant pulse is high is the same request completing, not a new one.
  assign valid_eff   = req_valid & ~req_ready_q;
  assign want_slow   = req_slow | force_d;
  assign pending_d   = cfg_pending_q | cfg_we;
  assign tmo_inc     = tmo_q + TMO_W'(1);
  assign tmo_expired = (tmo_inc == TMO_LIMIT);

  // Switch sequencing FSM; every output is a register updated here.
  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      state_q       <= ST_SLOW;
      req_ready_q   <= 1'b0;
      hsclk_sel_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      div_q         <= DIV_RST;
      force_q       <= 1'b0;
      div_shadow_q  <= DIV_RST;
      cfg_pending_q <= 1'b0;
      hold_q        <= HOLD_RELOAD;
      tmo_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      force_q      <= force_d;
      div_shadow_q <= div_shadow_d;
      req_ready_q  <= 1'b0;

      unique case (state_q)
        ST_FAST: begin
          cfg_pending_q <= pending_d;
          if (valid_eff && !want_slow) begin
            req_ready_q <= 1'b1;
          end else if (valid_eff || pending_d) begin
            // Slow request, forced slow, or dividers waiting to be applied.
            hsclk_sel_q <= 1'b0;
            tmo_q       <= '0;
            state_q     <= ST_WAIT_LS;
          end
        end

        ST_WAIT_LS: begin
          if (!hsclk_selected || tmo_expired) begin
            if (hsclk_selected) timeout_err_q <= 1'b1;
            state_q       <= ST_SLOW;
            hold_q        <= HOLD_RELOAD;
            div_q         <= div_shadow_d;
            cfg_pending_q <= 1'b0;
            if (valid_eff) req_ready_q <= 1'b1;
          end else begin
            tmo_q <= tmo_inc;
          end
        end

        ST_SLOW: begin
          div_q         <= div_shadow_d;
          cfg_pending_q <= 1'b0;
          if (valid_eff && want_slow) begin
            req_ready_q <= 1'b1;
            hold_q      <= HOLD_RELOAD;
          end else if (valid_eff && hold_q != '0) begin
            // Fast request inside the hysteresis window runs at low speed.
            req_ready_q <= 1'b1;
          end else if (valid_eff || (hold_q == '0 && !force_d)) begin
            hsclk_sel_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= ST_WAIT_HS;
          end else if (hold_q != '0) begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end

        ST_WAIT_HS: begin
          cfg_pending_q <= pending_d;
          if (hsclk_selected || tmo_expired) begin
            if (!hsclk_selected) timeout_err_q <= 1'b1;
            state_q <= ST_FAST;
            // A pending slow request is left for FAST, which switches straight back.
            if (valid_eff && !want_slow) req_ready_q <= 1'b1;
          end else begin
            tmo_q <= tmo_inc;
          end
        end

        default: state_q <= ST_SLOW;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign hsclk_sel      = hsclk_sel_q;
  assign timeout_err    = timeout_err_q;
  assign hsclk_div_sel  = div_q[3:2];
  assign cpuclk_div_sel = div_q[1:0];

endmodule

// File: tb/tb_clksel_ctrl.sv
// Self-checking bench for clksel_ctrl: scenario tasks plus randomized traffic
// against a cycle-level behavioural model of the switch-sequencing rules.
module tb_clksel_ctrl;

  localparam int HOLD = 16;
  localparam int TMO  = 255;

  logic       hsclk_in = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_slow;
  logic       req_ready;
  logic       cfg_we;
  logic [4:0] cfg_wdata;
  logic       hsclk_selected;
  logic       hsclk_sel;
  logic [1:0] hsclk_div_sel;
  logic [1:0] cpuclk_div_sel;
  logic       timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 hsclk_in = ~hsclk_in;

  clksel_ctrl #(
    .HOLD_CYCLES    (HOLD),
    .HOLD_W         (8),
    .SWITCH_TIMEOUT (TMO),
    .TMO_W          (8),
    .DIV_RST        (4'h0)
  ) dut (
    .hsclk_in       (hsclk_in),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_slow       (req_slow),
    .req_ready      (req_ready),
    .cfg_we         (cfg_we),
    .cfg_wdata      (cfg_wdata),
    .hsclk_selected (hsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .hsclk_div_sel  (hsclk_div_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .timeout_err    (timeout_err)
  );

  logic [6:0] dut_vec;
  assign dut_vec = {req_ready, hsclk_sel, hsclk_div_sel, cpuclk_div_sel, timeout_err};

  // ---------------- behavioural model ----------------
  // Speed is described by two flags: which clock is requested (m_sel) and
  // whether a switch toward it is still unconfirmed (m_wait).
  bit         m_sel, m_wait, m_ready, m_err, m_pend, sh_force;
  int         m_hold, m_tmo;
  logic [3:0] m_div, sh_div;
  bit         req_done;

  // Clock-switch emulator: follows the requested clock after sw_lat cycles.
  bit sw_stuck;
  int sw_lat, sw_cnt;

  function automatic logic [6:0] exp_vec();
    return {m_ready, m_sel, m_div, m_err};
  endfunction

  function automatic bit m_is_fast();
    return m_sel && !m_wait;
  endfunction

  function automatic bit m_is_slow();
    return !m_sel && !m_wait;
  endfunction

  task automatic model_edge();
    bit nf, v, ws, done, n_ready;
    logic [3:0] nd;
    int cnt;
    if (rst) begin
      m_sel = 0; m_wait = 0; m_ready = 0; m_err = 0; m_pend = 0;
      sh_force = 0; sh_div = 4'h0; m_div = 4'h0; m_hold = HOLD; m_tmo = 0;
      req_done = 0;
      return;
    end
    nf = cfg_we ? cfg_wdata[4] : sh_force;
    nd = cfg_we ? cfg_wdata[3:0] : sh_div;
    v  = req_valid && !m_ready;
    ws = req_slow || nf;
    req_done = m_ready && req_valid;
    n_ready = 0;
    if (m_is_fast()) begin
      m_pend = m_pend || cfg_we;
      if (v && !ws) n_ready = 1;
      else if (v || m_pend) begin m_sel = 0; m_wait = 1; m_tmo = 0; end
    end else if (m_wait) begin
      cnt  = m_tmo + 1;
      done = (hsclk_selected == m_sel);
      if (m_sel) m_pend = m_pend || cfg_we;
      if (done || cnt == TMO) begin
        if (!done) m_err = 1;
        m_wait = 0;
        if (!m_sel) begin
          m_hold = HOLD; m_div = nd; m_pend = 0; n_ready = v;
        end else begin
          n_ready = v && !ws;
        end
      end else begin
        m_tmo = cnt;
      end
    end else begin
      m_div = nd; m_pend = 0;
      if (v && ws) begin n_ready = 1; m_hold = HOLD; end
      else if (v && m_hold != 0) n_ready = 1;
      else if (v || (m_hold == 0 && !nf)) begin m_sel = 1; m_wait = 1; m_tmo = 0; end
      else if (m_hold != 0) m_hold--;
    end
    sh_force = nf;
    sh_div   = nd;
    m_ready  = n_ready;
  endtask

  // One clock: model follows the edge, switch emulator reacts 1 time unit later.
  task automatic step();
    @(posedge hsclk_in);
    model_edge();
    #1;
    if (!sw_stuck && hsclk_selected != m_sel) begin
      sw_cnt++;
      if (sw_cnt >= sw_lat) begin
        hsclk_selected = m_sel;
        sw_cnt = 0;
      end
    end else begin
      sw_cnt = 0;
    end
  endtask

  // Bus master: holds a request until its grant completes, then may issue another.
  task automatic master(input int pct_req, input int pct_slow);
    if (req_done) req_valid = 1'b0;
    if (!req_valid && $urandom_range(99) < pct_req) begin
      req_valid = 1'b1;
      req_slow  = ($urandom_range(99) < pct_slow);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && req_valid; i++) begin
      step();
      master(0, 0);
    end
  endtask

  task automatic goto_fast(input int budget, output bit ok);
    for (int i = 0; i < budget && !m_is_fast(); i++) step();
    ok = m_is_fast();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 0; req_slow = 0; cfg_we = 0; cfg_wdata = '0;
    hsclk_selected = 1'b0; sw_stuck = 0; sw_lat = 3; sw_cnt = 0;
    repeat (3) step();
    tests_run++;
    if (dut_vec !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", dut_vec, 7'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_boot_to_fast();
    int cnt;
    bit ok;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cnt++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL boot cyc %0d: got %b expected %b", cnt, dut_vec, exp_vec());
      end
      if (hsclk_sel === 1'b1) break;
    end
    // Hold counts down 16 cycles to zero, the next decision requests high speed.
    tests_run++;
    if (cnt != HOLD + 1) begin
      tests_failed++;
      $display("FAIL boot_hold_len: got %0d expected %0d", cnt, HOLD + 1);
    end
    goto_fast(20, ok);
    tests_run++;
    if (!ok || hsclk_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL boot_reach_fast: hsclk_sel %b expected 1", hsclk_sel);
    end
  endtask

  task automatic test_fast_grant();
    int cnt;
    req_valid = 1; req_slow = 0;
    step();
    tests_run++;
    if (req_ready !== 1'b1 || dut_vec !== exp_vec()) begin
      tests_failed++;
      $display("FAIL fast_grant_latency: got %b expected %b", dut_vec, exp_vec());
    end
    step();
    req_valid = 0;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fast_grant_single: req_ready %b expected 0", req_ready);
    end
    sw_lat = 3;
    req_valid = 1; req_slow = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL slow_switch cyc %0d: got %b expected %b", cnt, dut_vec, exp_vec());
      end
      if (req_ready === 1'b1) break;
    end
    tests_run++;
    if (cnt != sw_lat + 1 || hsclk_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL slow_grant_latency: got %0d cycles sel %b expected %0d cycles sel 0",
               cnt, hsclk_sel, sw_lat + 1);
    end
    step();
    master(0, 0);
  endtask

  task automatic test_hold_fast_req();
    int cnt;
    for (int i = 0; i < 30 && m_hold != 5; i++) step();
    req_valid = 1; req_slow = 0;
    step();
    tests_run++;
    if (req_ready !== 1'b1 || hsclk_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_fast_req_slow_grant: ready %b sel %b expected ready 1 sel 0",
               req_ready, hsclk_sel);
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      master(0, 0);
      cnt++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL hold_expire cyc %0d: got %b expected %b", cnt, dut_vec, exp_vec());
      end
      if (hsclk_sel === 1'b1) break;
    end
    // Remaining hold of 5 drains over 5 cycles, then one decision cycle.
    tests_run++;
    if (cnt != 6) begin
      tests_failed++;
      $display("FAIL hold_expire_len: got %0d expected 6", cnt);
    end
  endtask

  task automatic test_cfg_pending();
    bit ok;
    goto_fast(20, ok);
    cfg_we = 1; cfg_wdata = 5'b0_10_01;
    step();
    cfg_we = 0;
    tests_run++;
    if ({hsclk_div_sel, cpuclk_div_sel} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL cfg_not_in_fast: got %b expected 0000", {hsclk_div_sel, cpuclk_div_sel});
    end
    for (int i = 0; i < 40 && !m_is_slow(); i++) begin
      step();
      tests_run++;
      if (!m_is_slow() && {hsclk_div_sel, cpuclk_div_sel} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL cfg_early_apply: got %b expected 0000", {hsclk_div_sel, cpuclk_div_sel});
      end
    end
    tests_run++;
    if (hsclk_div_sel !== 2'b10 || cpuclk_div_sel !== 2'b01 || hsclk_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_apply_slow: got %b_%b sel %b expected 10_01 sel 0",
               hsclk_div_sel, cpuclk_div_sel, hsclk_sel);
    end
    goto_fast(40, ok);
    tests_run++;
    if (!ok || hsclk_sel !== 1'b1 || dut_vec !== exp_vec()) begin
      tests_failed++;
      $display("FAIL cfg_pending_cleared: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_force_slow();
    bit slow_seen, ok;
    cfg_we = 1; cfg_wdata = 5'b1_10_01;
    step();
    cfg_we = 0;
    slow_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      master(30, 50);
      step();
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL force_model cyc %0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (m_is_slow()) slow_seen = 1;
      if (slow_seen) begin
        tests_run++;
        if (hsclk_sel !== 1'b0) begin
          tests_failed++;
          $display("FAIL force_stays_slow cyc %0d: hsclk_sel %b expected 0", i, hsclk_sel);
        end
      end
    end
    master(0, 0);
    drain();
    cfg_we = 1; cfg_wdata = 5'b0_10_01;
    step();
    cfg_we = 0;
    goto_fast(100, ok);
    tests_run++;
    if (!ok || hsclk_sel !== 1'b1 || dut_vec !== exp_vec()) begin
      tests_failed++;
      $display("FAIL force_release: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_timeout();
    int cnt;
    bit ok;
    goto_fast(40, ok);
    sw_stuck = 1;
    req_valid = 1; req_slow = 1;
    step();
    tests_run++;
    if (hsclk_sel !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_start: sel %b err %b expected sel 0 err 0", hsclk_sel, timeout_err);
    end
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      cnt++;
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL timeout_wait cyc %0d: got %b expected %b", cnt, dut_vec, exp_vec());
      end
      if (timeout_err === 1'b1) break;
    end
    tests_run++;
    if (cnt != TMO || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d cycles ready %b expected %0d cycles ready 1",
               cnt, req_ready, TMO);
    end
    sw_stuck = 0;
    for (int i = 0; i < 200; i++) begin
      master(30, 50);
      step();
      tests_run++;
      if (timeout_err !== 1'b1 || dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL timeout_sticky cyc %0d: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    rst = 1; req_valid = 0; req_slow = 0;
    step();
    step();
    tests_run++;
    if (timeout_err !== 1'b0 || dut_vec !== 7'b0) begin
      tests_failed++;
      $display("FAIL timeout_rst_clear: got %b expected %b", dut_vec, 7'b0);
    end
    rst = 0;
  endtask

  task automatic test_random();
    logic prev_ready;
    prev_ready = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      master(40, 40);
      if ($urandom_range(99) < 3) begin
        cfg_we = 1;
        cfg_wdata = {($urandom_range(99) < 20), 4'($urandom_range(15))};
      end else begin
        cfg_we = 0;
      end
      if (sw_cnt == 0) sw_lat = $urandom_range(1, 6);
      step();
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cyc %0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      tests_run++;
      if (prev_ready === 1'b1 && req_ready === 1'b1) begin
        tests_failed++;
        $display("FAIL random_ready_pulse cyc %0d: req_ready %b expected 0", i, req_ready);
      end
      prev_ready = req_ready;
    end
    cfg_we = 0;
  endtask

  initial begin
    test_reset();
    test_boot_to_fast();
    test_fast_grant();
    test_hold_fast_req();
    test_cfg_pending();
    test_force_slow();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
